// File: rtl/mr_keystream_packer_if.sv
// Keystream packer port bundle: LFSR state inputs, bit tap, and the word valid/ready stream.
// master = packer side, slave = environment (LFSR feeder plus word consumer).
interface mr_keystream_packer_if #(
    parameter int WIDTH  = 13,
    parameter int WORD_W = 8
);
    logic [WIDTH-1:0]  i_lfsr_l;
    logic [WIDTH-1:0]  i_lfsr_s;
    logic              i_en;
    logic              o_bit;
    logic              o_bit_vld;
    logic [WORD_W-1:0] o_data;
    logic              o_valid;
    logic              i_ready;
    logic              o_ovf;

    modport master (
        input  i_lfsr_l, i_lfsr_s, i_en, i_ready,
        output o_bit, o_bit_vld, o_data, o_valid, o_ovf
    );

    modport slave (
        output i_lfsr_l, i_lfsr_s, i_en, i_ready,
        input  o_bit, o_bit_vld, o_data, o_valid, o_ovf
    );
endinterface

// File: rtl/mr_keystream_packer.sv
// Massey-Rueppel output stage: inner-product bit, warm-up discard, LSB-first packing, 2-entry FIFO.
// Sample-to-word latency 2 edges; a word completing into a full FIFO with no pop is dropped and o_ovf sticks.
module mr_keystream_packer #(
    parameter int WIDTH  = 13,
    parameter int WORD_W = 8,
    parameter int WARMUP = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    mr_keystream_packer_if.master bus
);
    localparam int                IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [15:0]       WARM  = 16'(WARMUP);
    localparam logic [IDX_W-1:0]  LAST  = IDX_W'(WORD_W - 1);

    logic              bit_q, bit_d, bit_vld_q, bit_vld_d;
    logic [15:0]       warm_q, warm_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] shift_q, shift_d, word_w;
    logic [WORD_W-1:0] mem_q [2];
    logic [WORD_W-1:0] mem_d [2];
    logic              rd_q, rd_d, wr_q, wr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [WIDTH-1:0]  prod;
    logic              accept, push, pop, full, wr_ok;

    always_comb begin
        prod      = bus.i_lfsr_l & bus.i_lfsr_s;
        bit_d     = bit_q;
        bit_vld_d = 1'b0;
        if (bus.i_en) begin
            bit_d     = ^prod;
            bit_vld_d = 1'b1;
        end

        // Counter only ever climbs to WARM, so inequality is the same as "still warming up".
        accept = bit_vld_q && (warm_q == WARM);
        warm_d = warm_q;
        if (bit_vld_q && (warm_q != WARM)) warm_d = warm_q + 16'd1;

        word_w         = shift_q;
        word_w[idx_q]  = bit_q;
        shift_d        = shift_q;
        idx_d          = idx_q;
        push           = 1'b0;
        if (accept) begin
            shift_d = word_w;
            if (idx_q == LAST) begin
                idx_d = '0;
                push  = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end

        // When full, wr_q equals rd_q: a push+pop overwrites the slot being popped.
        pop   = (cnt_q != 2'd0) && bus.i_ready;
        full  = (cnt_q == 2'd2);
        wr_ok = push && (!full || pop);
        mem_d = mem_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        ovf_d = ovf_q;
        cnt_d = cnt_q;
        if (pop) rd_d = ~rd_q;
        if (wr_ok) begin
            mem_d[wr_q] = word_w;
            wr_d        = ~wr_q;
        end
        if (push && full && !pop) ovf_d = 1'b1;
        case ({wr_ok, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bit_q     <= 1'b0;
            bit_vld_q <= 1'b0;
            warm_q    <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            mem_q[0]  <= '0;
            mem_q[1]  <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            bit_q     <= bit_d;
            bit_vld_q <= bit_vld_d;
            warm_q    <= warm_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            mem_q     <= mem_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.o_bit     = bit_q;
    assign bus.o_bit_vld = bit_vld_q;
    assign bus.o_data    = mem_q[rd_q];
    assign bus.o_valid   = (cnt_q != 2'd0);
    assign bus.o_ovf     = ovf_q;
endmodule

// File: tb/tb_mr_keystream_packer.sv
// Directed bench for mr_keystream_packer: two instances (WARMUP=0 and WARMUP=16) share stimulus;
// a per-instance reference model feeds scoreboard queues that are popped on each handshake.
module tb_mr_keystream_packer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        rdy = 1'b0;
    logic [12:0] l   = '0;
    logic [12:0] s   = '0;

    always #5 clk = ~clk;

    mr_keystream_packer_if #(.WIDTH(13), .WORD_W(8)) ifa ();
    mr_keystream_packer_if #(.WIDTH(13), .WORD_W(8)) ifb ();

    assign ifa.i_lfsr_l = l;
    assign ifa.i_lfsr_s = s;
    assign ifa.i_en     = en;
    assign ifa.i_ready  = rdy;
    assign ifb.i_lfsr_l = l;
    assign ifb.i_lfsr_s = s;
    assign ifb.i_en     = en;
    assign ifb.i_ready  = rdy;

    mr_keystream_packer #(.WIDTH(13), .WORD_W(8), .WARMUP(0))  u_a (.i_clk(clk), .i_rst(rst), .bus(ifa));
    mr_keystream_packer #(.WIDTH(13), .WORD_W(8), .WARMUP(16)) u_b (.i_clk(clk), .i_rst(rst), .bus(ifb));

    int tests = 0;
    int fails = 0;

    int         warm_m [2];
    int         idx_m  [2];
    logic [7:0] acc_m  [2];
    logic       pv_m   [2];
    logic       bit_m  [2];
    logic       ovf_m  [2];
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    logic [7:0] popped_a[$];
    logic [7:0] popped_b[$];
    int         vcnt_a = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one instance at the coming edge, from the pre-edge inputs.
    task automatic model_edge(input int k);
        int   w;
        int   qs;
        logic pop;
        w = (k == 0) ? 0 : 16;
        if (rst) begin
            warm_m[k] = 0; idx_m[k] = 0; acc_m[k] = '0;
            pv_m[k] = 1'b0; bit_m[k] = 1'b0; ovf_m[k] = 1'b0;
            if (k == 0) q_a.delete(); else q_b.delete();
            return;
        end
        qs  = (k == 0) ? q_a.size() : q_b.size();
        pop = (qs != 0) && rdy;
        if (pop) begin
            if (k == 0) popped_a.push_back(q_a.pop_front());
            else        popped_b.push_back(q_b.pop_front());
            qs--;
        end
        if (pv_m[k]) begin
            if (warm_m[k] < w) begin
                warm_m[k]++;
            end else begin
                acc_m[k][idx_m[k]] = bit_m[k];
                if (idx_m[k] == 7) begin
                    if (qs == 2) ovf_m[k] = 1'b1;
                    else if (k == 0) q_a.push_back(acc_m[k]);
                    else q_b.push_back(acc_m[k]);
                    idx_m[k] = 0;
                end else begin
                    idx_m[k]++;
                end
            end
        end
        pv_m[k] = en;
        if (en) bit_m[k] = ^(l & s);
    endtask

    task automatic check_outputs();
        chk("a_bit_vld", 32'(ifa.o_bit_vld), 32'(pv_m[0]));
        chk("a_bit",     32'(ifa.o_bit),     32'(bit_m[0]));
        chk("a_valid",   32'(ifa.o_valid),   32'(q_a.size() != 0));
        if (q_a.size() != 0) chk("a_data", 32'(ifa.o_data), 32'(q_a[0]));
        chk("a_ovf",     32'(ifa.o_ovf),     32'(ovf_m[0]));
        chk("b_bit_vld", 32'(ifb.o_bit_vld), 32'(pv_m[1]));
        chk("b_bit",     32'(ifb.o_bit),     32'(bit_m[1]));
        chk("b_valid",   32'(ifb.o_valid),   32'(q_b.size() != 0));
        if (q_b.size() != 0) chk("b_data", 32'(ifb.o_data), 32'(q_b[0]));
        chk("b_ovf",     32'(ifb.o_ovf),     32'(ovf_m[1]));
        if (ifa.o_valid) vcnt_a++;
    endtask

    task automatic tick();
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; rdy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        popped_a.delete();
        popped_b.delete();
        vcnt_a = 0;
    endtask

    initial begin
        logic exp_bit;
        int   first;

        // Reset with enable high and random LFSR states: everything stays zero.
        rst = 1'b1; en = 1'b1; rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            l = 13'($urandom); s = 13'($urandom);
            tick();
            chk("rst_a_bit",   32'(ifa.o_bit),     0);
            chk("rst_a_bvld",  32'(ifa.o_bit_vld), 0);
            chk("rst_a_data",  32'(ifa.o_data),    0);
            chk("rst_a_valid", 32'(ifa.o_valid),   0);
            chk("rst_a_ovf",   32'(ifa.o_ovf),     0);
            chk("rst_b_bvld",  32'(ifb.o_bit_vld), 0);
            chk("rst_b_valid", 32'(ifb.o_valid),   0);
        end
        rst = 1'b0;
        l = 13'h1ABC; s = 13'h0F35;
        exp_bit = ^(13'h1ABC & 13'h0F35);
        tick();
        chk("first_sample_bit", 32'(ifa.o_bit),     32'(exp_bit));
        chk("first_sample_vld", 32'(ifa.o_bit_vld), 1);
        chk("post_rst_valid",   32'(ifa.o_valid),   0);
        chk("post_rst_data",    32'(ifa.o_data),    0);
        chk("post_rst_ovf",     32'(ifa.o_ovf),     0);

        // Inner product and LSB-first packing.
        do_reset();
        rdy = 1'b1; en = 1'b1; l = 13'h1FFF;
        for (int i = 0; i < 8; i++) begin
            s = (i % 2 == 0) ? 13'h0001 : 13'h0000;
            tick();
            chk("alt_bit", 32'(ifa.o_bit), (i % 2 == 0) ? 1 : 0);
        end
        en = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("pack_word_cnt", popped_a.size(), 1);
        if (popped_a.size() > 0) chk("pack_word_55", 32'(popped_a[0]), 32'h55);
        chk("pack_valid_cycles", vcnt_a, 1);

        // Warm-up discard on the WARMUP=16 instance.
        do_reset();
        rdy = 1'b1; en = 1'b1;
        l = 13'h0003; s = 13'h0003;
        for (int i = 0; i < 16; i++) tick();
        l = 13'h0007; s = 13'h0007;
        for (int i = 0; i < 8; i++) tick();
        en = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("warm_word_cnt", popped_b.size(), 1);
        if (popped_b.size() > 0) chk("warm_word_ff", 32'(popped_b[0]), 32'hFF);
        foreach (popped_b[i]) chk("warm_no_zero_word", 32'(popped_b[i] != 8'h00), 1);

        // Enable toggling stalls the packer.
        do_reset();
        rdy = 1'b1; l = 13'h1FFF; s = 13'h1FFF;
        first = 0;
        for (int i = 1; i <= 20; i++) begin
            en = (i % 2 == 1);
            tick();
            if (ifa.o_valid && first == 0) first = i;
        end
        en = 1'b0;
        chk("stall_first_valid_cycle", first, 16);
        if (popped_a.size() > 0) chk("stall_word_ff", 32'(popped_a[0]), 32'hFF);

        // Backpressure: third word is dropped and o_ovf sticks.
        do_reset();
        rdy = 1'b0; en = 1'b1; l = 13'h1FFF; s = 13'h1FFF;
        for (int i = 1; i <= 24; i++) begin
            tick();
            if (i >= 9) chk("bp_data_stable", 32'(ifa.o_data), 32'hFF);
        end
        chk("bp_ovf_before", 32'(ifa.o_ovf), 0);
        en = 1'b0;
        tick();
        chk("bp_ovf_rise",  32'(ifa.o_ovf),   1);
        chk("bp_valid",     32'(ifa.o_valid), 1);
        rdy = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("bp_pop_cnt",   popped_a.size(), 2);
        chk("bp_ovf_stick", 32'(ifa.o_ovf), 1);
        do_reset();
        chk("bp_ovf_cleared", 32'(ifa.o_ovf), 0);

        // Full FIFO with push and pop on the same edge.
        rdy = 1'b0; en = 1'b1; l = 13'h1FFF;
        for (int i = 1; i <= 24; i++) begin
            s = 13'($urandom);
            tick();
        end
        en = 1'b0; rdy = 1'b1;
        tick();
        chk("full_pp_ovf",   32'(ifa.o_ovf),   0);
        chk("full_pp_valid", 32'(ifa.o_valid), 1);
        for (int i = 0; i < 4; i++) tick();
        chk("full_pp_pop_cnt", popped_a.size(), 3);
        chk("full_pp_empty",   32'(ifa.o_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mr_keystream_packer.md
# mr_keystream_packer

Output stage of the Massey-Rueppel PRNG, directly downstream of the two 13-bit LFSRs (fast LFSR L, stepping two positions per clock, and slow LFSR S). Each enabled cycle it forms one keystream bit as the GF(2) inner product of the two LFSR states. It discards a warm-up prefix, packs bits LSB-first into WORD_W-bit words, and delivers them through a 2-entry FIFO with a valid/ready handshake.

## Interface
- WIDTH, 13, LFSR state width.
- WORD_W, 8, output word width (2..32).
- WARMUP, 16, number of keystream bits discarded after reset (0 = none; up to 2^16-1).
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_lfsr_l  in  WIDTH  current state of fast LFSR L.
- i_lfsr_s  in  WIDTH  current state of slow LFSR S.
- i_en  in  1  sample enable; inputs are used only when high.
- o_bit  out  1  registered keystream bit.
- o_bit_vld  out  1  o_bit was produced from an enabled sample.
- o_data  out  WORD_W  FIFO head word.
- o_valid  out  1  FIFO non-empty.
- i_ready  in  1  consumer accepts o_data when o_valid & i_ready.
- o_ovf  out  1  sticky overflow flag: a completed word was dropped.

## Operation
- Stage 1, bit register, on every edge:
  - If i_en, then o_bit <= ^(i_lfsr_l & i_lfsr_s) and o_bit_vld <= 1.
  - Otherwise o_bit holds and o_bit_vld <= 0.
- Stage 2, warm-up counter (16-bit): each edge with o_bit_vld=1 while count < WARMUP, the bit is discarded and the count increments. Once count = WARMUP, the counter saturates and bits go to the packer.
- Packer: shift register plus bit index 0..WORD_W-1.
  - An accepted bit is written at position idx, so the first bit lands at bit 0 (LSB-first).
  - When idx = WORD_W-1, the completed word (including the current bit) is pushed to the FIFO and idx wraps to 0.
- FIFO: 2 entries, 2-bit occupancy.
  - Pop on o_valid & i_ready.
  - A push when full with no pop in the same cycle drops the new word, sets o_ovf = 1 (held until reset), and leaves FIFO contents unchanged.
  - A push and pop in the same cycle while full is legal: both happen, occupancy stays 2, o_ovf unchanged.
  - A push and pop in the same cycle with 1 entry leaves occupancy at 1 and the new word becomes head.
- o_data is the head entry. It must hold stable while o_valid & !i_ready.
- Reset mid-operation clears the warm-up counter, packer index and shift data, FIFO occupancy and o_ovf. A partial word is lost.
- i_en low stalls the packer only; FIFO pops continue.

## Timing
- Reset values: o_bit=0, o_bit_vld=0, o_data=0, o_valid=0, o_ovf=0. Internal counters are 0.
- Sample at edge E gives o_bit/o_bit_vld visible after E.
- Packing happens at E+1. If that bit completes a word, o_valid=1 after E+1. Sample-to-word latency for the last bit is 2 edges (FIFO empty).
- Throughput: one bit per cycle, so one word per WORD_W cycles. The consumer must pop at least once per WORD_W cycles to avoid overflow in steady state.
- The first i_en cycle after i_rst deasserts is sampled. With WARMUP=16 and i_en held high, the first accepted bit comes from sample 17. The first word is then visible WORD_W-1 samples later plus 2 edges.
- No combinational path from inputs to outputs.

## Test plan
- Reset values: assert i_rst for 3 cycles with i_en=1 and random states -> all outputs 0 throughout and one cycle after deassert, except o_bit/o_bit_vld, which follow the first sample.
- Inner product and packing: WARMUP=0, i_lfsr_l=13'h1FFF, i_lfsr_s alternating 13'h0001 / 13'h0000 starting with 13'h0001, i_ready=1 -> o_bit alternates 1,0,… and first word o_data=8'h55 with o_valid high for exactly 1 cycle.
- Warm-up: default WARMUP=16, i_lfsr_l=i_lfsr_s=13'h0003 (bit=0) for 16 samples, then 13'h0007 (bit=1) -> the first word is 8'hFF; no word of zeros ever appears.
- Stall/enable: WARMUP=0, all-ones bits with i_en toggling 1,0,1,0… -> the word completes after 8 enabled samples (16 cycles); o_data=8'hFF.
- Backpressure/overflow: WARMUP=0, i_ready=0 for 3 words of all ones -> o_valid stays 1, o_data stable at 8'hFF, o_ovf rises on the edge pushing word 3. Then i_ready=1 -> exactly 2 words popped, o_ovf stays 1 until i_rst.
- Full push+pop: FIFO full, i_ready=1 on the edge a word completes -> no overflow, occupancy stays 2, words pop in order.
